// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle execute stage: op codes, flag bits, FSM states, operand selects.
// Optional feature macro used by the stage: EX_SIGNED_DIV_EN (signed DIVS/REMS).
package ex_pkg;

    localparam int EX_DATA_W  = 32;
    localparam int EX_SHAMT_W = 5;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_BNE   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_DIVU  = 4'hB;
    localparam logic [3:0] OP_REMU  = 4'hC;
    localparam logic [3:0] OP_DIVS  = 4'hD;
    localparam logic [3:0] OP_REMS  = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        A_SEL_PC   = 2'd0,
        A_SEL_PC1  = 2'd1,
        A_SEL_DATA = 2'd2,
        A_SEL_ZERO = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_IMM      = 2'd0,
        B_SEL_DATA     = 2'd1,
        B_SEL_IMM_SRA2 = 2'd2,
        B_SEL_ZERO     = 2'd3
    } b_sel_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMS);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REMU) || (op == OP_REMS);
    endfunction

endpackage

// File: rtl/ex_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one step counter.
// With EX_SIGNED_DIV_EN defined, DIVS/REMS divide magnitudes and fix the signs afterwards.
module ex_iter_muldiv
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic              div0
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] acc_q, sh_q, bq_q;
    logic [DATA_W-1:0] acc_nxt, sh_nxt, bq_nxt;
    logic [DATA_W-1:0] a_load, b_load;
    logic [DATA_W-1:0] quot_raw, rem_raw, quot_fix, rem_fix;
    logic [DATA_W-1:0] diff;
    logic [DATA_W:0]   trial;
    logic [CNT_W-1:0]  cnt_q;
    logic              active_q, mul_q, rem_q, div0_q;
    logic              q_bit;

`ifdef EX_SIGNED_DIV_EN
    logic sgn_op, neg_quot_q, neg_rem_q;

    assign sgn_op = (op == OP_DIVS) || (op == OP_REMS);
    assign a_load = (sgn_op && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign b_load = (sgn_op && b[DATA_W-1]) ? (~b + 1'b1) : b;
`else
    assign a_load = a;
    assign b_load = b;
`endif

    // The last step is never registered: it is evaluated combinationally so the
    // parent can capture the result in the same cycle the counter reaches the end.
    assign done = active_q && (cnt_q == LAST_STEP);

    always_comb begin
        acc_nxt = acc_q;
        sh_nxt  = sh_q;
        bq_nxt  = bq_q;
        q_bit   = 1'b0;
        trial   = {acc_q, sh_q[DATA_W-1]};
        diff    = trial[DATA_W-1:0] - bq_q;
        if (mul_q) begin
            if (sh_q[0]) begin
                acc_nxt = acc_q + bq_q;
            end
            bq_nxt = bq_q << 1;
            sh_nxt = sh_q >> 1;
        end else begin
            q_bit   = (trial >= {1'b0, bq_q});
            acc_nxt = q_bit ? diff : trial[DATA_W-1:0];
            sh_nxt  = {sh_q[DATA_W-2:0], q_bit};
        end
    end

    assign quot_raw = sh_nxt;
    assign rem_raw  = acc_nxt;

`ifdef EX_SIGNED_DIV_EN
    assign quot_fix = (neg_quot_q && !div0_q) ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
`else
    assign quot_fix = quot_raw;
    assign rem_fix  = rem_raw;
`endif

    assign res  = mul_q ? acc_nxt : (rem_q ? rem_fix : quot_fix);
    assign div0 = div0_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            sh_q     <= '0;
            bq_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
            mul_q    <= (op == OP_MUL);
            rem_q    <= is_rem_op(op);
            div0_q   <= (op != OP_MUL) && (b == '0);
            if (op == OP_MUL) begin
                sh_q <= b;
                bq_q <= a;
            end else begin
                sh_q <= a_load;
                bq_q <= b_load;
            end
        end else if (active_q && !done) begin
            acc_q <= acc_nxt;
            sh_q  <= sh_nxt;
            bq_q  <= bq_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef EX_SIGNED_DIV_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (start) begin
            neg_quot_q <= sgn_op && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_rem_q  <= sgn_op && a[DATA_W-1];
        end
    end
`endif

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: operand muxes, single-cycle ALU, branch resolution and a registered output bundle,
// with MUL/DIV/REM handed to ex_iter_muldiv. Signed divide is enabled by EX_SIGNED_DIV_EN.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W  = EX_DATA_W,
    parameter int SHAMT_W = EX_SHAMT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [1:0]        a_sel,
    input  logic [1:0]        b_sel,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] pc_1,
    input  logic [DATA_W-1:0] immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flag,
    output logic [DATA_W-1:0] next_pc,
    output logic              branch_taken,
    output logic              busy
);

    logic [1:0]        state_q;
    logic              out_valid_q, taken_q;
    logic [DATA_W-1:0] result_q, next_pc_q, pc_1_hold;
    logic [2:0]        flag_q;

    logic [DATA_W-1:0] a_op, b_op, alu_res, next_pc_c, iter_res;
    logic              alu_ovf, taken_c, iter_done, iter_div0;
    logic              out_free, accept, start_iter, load_single, load_iter;

    function automatic logic [2:0] make_flag(input logic [DATA_W-1:0] r, input logic v);
        logic [2:0] f;
        f            = '0;
        f[FLAG_ZERO] = (r == '0);
        f[FLAG_NEG]  = r[DATA_W-1];
        f[FLAG_OVF]  = v;
        return f;
    endfunction

    assign out_free    = !out_valid_q || out_ready;
    assign in_ready    = (state_q == ST_IDLE) && out_free && !flush;
    assign accept      = in_valid && in_ready;
    assign start_iter  = accept && is_iter_op(op);
    assign load_single = accept && !is_iter_op(op);
    assign load_iter   = ((state_q == ST_ITER) || (state_q == ST_DONE)) && iter_done && out_free;

    always_comb begin
        a_op = '0;
        case (a_sel)
            A_SEL_PC:   a_op = pc;
            A_SEL_PC1:  a_op = pc_1;
            A_SEL_DATA: a_op = data_a;
            default:    a_op = '0;
        endcase
    end

    always_comb begin
        b_op = '0;
        case (b_sel)
            B_SEL_IMM:      b_op = immediate;
            B_SEL_DATA:     b_op = data_b;
            B_SEL_IMM_SRA2: b_op = $signed(immediate) >>> 2;
            default:        b_op = '0;
        endcase
    end

    // Overflow is only meaningful for ADD/SUB; iterative ops leave this path unused.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        taken_c = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = a_op + b_op;
                alu_ovf = (a_op[DATA_W-1] == b_op[DATA_W-1]) && (alu_res[DATA_W-1] != a_op[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = a_op - b_op;
                alu_ovf = (a_op[DATA_W-1] != b_op[DATA_W-1]) && (alu_res[DATA_W-1] != a_op[DATA_W-1]);
            end
            OP_AND:   alu_res = a_op & b_op;
            OP_OR:    alu_res = a_op | b_op;
            OP_XOR:   alu_res = a_op ^ b_op;
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
            OP_SLL:   alu_res = a_op << b_op[SHAMT_W-1:0];
            OP_SRL:   alu_res = a_op >> b_op[SHAMT_W-1:0];
            OP_BEQ:   taken_c = (a_op == b_op);
            OP_BNE:   taken_c = (a_op != b_op);
            OP_PASSB: alu_res = b_op;
            default:  alu_res = '0;
        endcase
    end

    assign next_pc_c = taken_c ? (pc_1 + immediate) : pc_1;

    ex_iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (start_iter),
        .op    (op),
        .a     (a_op),
        .b     (b_op),
        .done  (iter_done),
        .res   (iter_res),
        .div0  (iter_div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_iter) state_q <= ST_ITER;
                ST_ITER: if (iter_done)  state_q <= out_free ? ST_IDLE : ST_DONE;
                ST_DONE: if (out_free)   state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The output bundle only changes when a new result is loaded into a free register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= '0;
            next_pc_q   <= '0;
            taken_q     <= 1'b0;
            pc_1_hold   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else begin
            if (start_iter) begin
                pc_1_hold <= pc_1;
            end
            if (load_single) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                flag_q      <= make_flag(alu_res, alu_ovf);
                next_pc_q   <= next_pc_c;
                taken_q     <= taken_c;
            end else if (load_iter) begin
                out_valid_q <= 1'b1;
                result_q    <= iter_res;
                flag_q      <= make_flag(iter_res, iter_div0);
                next_pc_q   <= pc_1_hold;
                taken_q     <= 1'b0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign flag         = flag_q;
    assign next_pc      = next_pc_q;
    assign branch_taken = taken_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: single-cycle ops, iterative mul/div latency, backpressure, flush, reset.
// Signed-divide expectations follow EX_SIGNED_DIV_EN.
module tb_ex_stage_mc;
    import ex_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [1:0]   a_sel, b_sel;
    logic [W-1:0] data_a, data_b, pc, pc_1, immediate, result, next_pc;
    logic [2:0]   flag;
    logic         branch_taken, busy;

    int checks   = 0;
    int failures = 0;
    int bad;

    ex_stage_mc #(.DATA_W(W), .SHAMT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .data_a       (data_a),
        .data_b       (data_b),
        .pc           (pc),
        .pc_1         (pc_1),
        .immediate    (immediate),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag         (flag),
        .next_pc      (next_pc),
        .branch_taken (branch_taken),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBundle(input string tag, input logic [W-1:0] res, input logic [2:0] flg,
                               input logic [W-1:0] npc, input logic tk);
        checkOutput({tag, "_valid"}, W'(out_valid), 1);
        checkOutput({tag, "_result"}, result, res);
        checkOutput({tag, "_flag"}, W'(flag), W'(flg));
        checkOutput({tag, "_next_pc"}, next_pc, npc);
        checkOutput({tag, "_taken"}, W'(branch_taken), W'(tk));
    endtask

    task automatic applyStimulus(input logic [3:0] o, input logic [1:0] as, input logic [1:0] bs,
                                 input logic [W-1:0] da, input logic [W-1:0] db,
                                 input logic [W-1:0] p1, input logic [W-1:0] imm);
        op = o; a_sel = as; b_sel = bs; data_a = da; data_b = db;
        pc = p1 - 1; pc_1 = p1; immediate = imm; in_valid = 1'b1;
        #1;
        checkOutput("accept_ready", W'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input logic [W-1:0] res, input logic [2:0] flg,
                              input logic [W-1:0] npc);
        int n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput({tag, "_latency"}, W'(n), W + 1);
        checkBundle(tag, res, flg, npc, 1'b0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = OP_ADD; a_sel = 2'd0; b_sel = 2'd0;
        data_a = '0; data_b = '0; pc = '0; pc_1 = '0; immediate = '0;
        #1;
        checkOutput("rst_valid", W'(out_valid), 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flag", W'(flag), 0);
        checkOutput("rst_next_pc", next_pc, 0);
        checkOutput("rst_taken", W'(branch_taken), 0);
        checkOutput("rst_busy", W'(busy), 0);
        tick(); tick();
        reset = 1'b1;

        applyStimulus(OP_ADD, 2'd2, 2'd1, 7, 5, 32'h104, 0);
        checkBundle("add", 12, 3'b000, 32'h104, 1'b0);
        applyStimulus(OP_ADD, 2'd2, 2'd1, 32'h7FFF_FFFF, 1, 32'h108, 0);
        checkBundle("add_ovf", 32'h8000_0000, 3'b110, 32'h108, 1'b0);
        applyStimulus(OP_SUB, 2'd2, 2'd1, 5, 5, 32'h10C, 0);
        checkBundle("sub_zero", 0, 3'b001, 32'h10C, 1'b0);
        applyStimulus(OP_SLT, 2'd2, 2'd1, 32'hFFFF_FFFF, 1, 32'h110, 0);
        checkBundle("slt", 1, 3'b000, 32'h110, 1'b0);
        applyStimulus(OP_SLL, 2'd2, 2'd1, 1, 33, 32'h114, 0);
        checkBundle("sll_mask", 2, 3'b000, 32'h114, 1'b0);
        applyStimulus(OP_SRL, 2'd2, 2'd1, 32'h8000_0000, 31, 32'h118, 0);
        checkBundle("srl", 1, 3'b000, 32'h118, 1'b0);
        applyStimulus(OP_PASSB, 2'd3, 2'd2, 0, 0, 32'h11C, 32'hFFFF_FFF0);
        checkBundle("passb_sra2", 32'hFFFF_FFFC, 3'b010, 32'h11C, 1'b0);
        applyStimulus(OP_ADD, 2'd0, 2'd3, 0, 0, 32'h300, 0);
        checkBundle("add_pc", 32'h2FF, 3'b000, 32'h300, 1'b0);
        applyStimulus(OP_BEQ, 2'd2, 2'd1, 3, 3, 32'h40, 32'h10);
        checkBundle("beq", 0, 3'b001, 32'h50, 1'b1);
        applyStimulus(OP_BNE, 2'd2, 2'd1, 3, 3, 32'h40, 32'h10);
        checkBundle("bne", 0, 3'b001, 32'h40, 1'b0);

        applyStimulus(OP_DIVU, 2'd2, 2'd1, 100, 7, 32'h500, 0);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        checkOutput("divu_busy_window", W'(bad), 0);
        checkBundle("divu", 14, 3'b000, 32'h500, 1'b0);
        checkOutput("divu_idle_ready", W'(in_ready), 1);

        applyStimulus(OP_REMU, 2'd2, 2'd1, 100, 7, 32'h504, 0);
        waitResult("remu", 2, 3'b000, 32'h504);
        applyStimulus(OP_DIVU, 2'd2, 2'd1, 1234, 0, 32'h508, 0);
        waitResult("divu_zero", 32'hFFFF_FFFF, 3'b110, 32'h508);
        applyStimulus(OP_REMU, 2'd2, 2'd1, 1234, 0, 32'h50C, 0);
        waitResult("remu_zero", 1234, 3'b100, 32'h50C);

        tick();
        out_ready = 1'b0;
        applyStimulus(OP_MUL, 2'd2, 2'd1, 6, 7, 32'h200, 0);
        waitResult("mul", 42, 3'b000, 32'h200);
        bad = 0;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b1 || result !== 42 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("mul_hold", W'(bad), 0);
        out_ready = 1'b1;
        #1;
        checkOutput("mul_release_ready", W'(in_ready), 1);
        tick();
        checkOutput("mul_drained", W'(out_valid), 0);

        applyStimulus(OP_DIVU, 2'd2, 2'd1, 100, 7, 32'h600, 0);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        checkOutput("flush_gate_ready", W'(in_ready), 0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_ready_next", W'(in_ready), 1);
        checkOutput("flush_busy_next", W'(busy), 0);
        bad = 0;
        repeat (40) begin
            if (out_valid !== 1'b0) bad++;
            tick();
        end
        checkOutput("flush_no_valid", W'(bad), 0);

        op = OP_ADD; a_sel = 2'd2; b_sel = 2'd1; data_a = 1; data_b = 1;
        in_valid = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", W'(in_ready), 0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_no_accept", W'(out_valid), 0);

        applyStimulus(OP_MUL, 2'd2, 2'd1, 9, 9, 32'h700, 0);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", W'(busy), 0);
        checkOutput("midrst_valid", W'(out_valid), 0);
        checkOutput("midrst_result", result, 0);
        checkOutput("midrst_flag", W'(flag), 0);
        checkOutput("midrst_next_pc", next_pc, 0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("postrst_ready", W'(in_ready), 1);

`ifdef EX_SIGNED_DIV_EN
        applyStimulus(OP_DIVS, 2'd2, 2'd1, 32'hFFFF_FF9C, 7, 32'h800, 0);
        waitResult("divs", 32'hFFFF_FFF2, 3'b010, 32'h800);
        applyStimulus(OP_REMS, 2'd2, 2'd1, 32'hFFFF_FF9C, 7, 32'h804, 0);
        waitResult("rems", 32'hFFFF_FFFE, 3'b010, 32'h804);
        applyStimulus(OP_DIVS, 2'd2, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h808, 0);
        waitResult("divs_min", 32'h8000_0000, 3'b010, 32'h808);
`else
        applyStimulus(OP_DIVS, 2'd2, 2'd1, 32'hFFFF_FF9C, 7, 32'h800, 0);
        waitResult("divs", 32'h2492_4916, 3'b000, 32'h800);
        applyStimulus(OP_REMS, 2'd2, 2'd1, 32'hFFFF_FF9C, 7, 32'h804, 0);
        waitResult("rems", 2, 3'b000, 32'h804);
        applyStimulus(OP_DIVS, 2'd2, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h808, 0);
        waitResult("divs_min", 0, 3'b001, 32'h808);
`endif

        applyStimulus(OP_MUL, 2'd2, 2'd1, 32'hFFFF_FFFD, 5, 32'h900, 0);
        waitResult("mul_neg", 32'hFFFF_FFF1, 3'b010, 32'h900);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
